fetch_dispatch_fsm: RTL and testbench

- Upstream control stage of the multi-cycle CPU.
- Fetches a 16-bit instruction from memory using the `memRead`/`mfc` handshake, then decodes its 4-bit opcode.
- Issues a one-cycle one-hot `nextFSM` start code plus operand fields `para1`/`para2` to the execution FSMs (ALU two-operand, ALU immediate, ALU NOT, move, movi, load, store).
- Waits for the matching completion pulse before fetching the next instruction.

---
 rtl/fetch_dispatch_if.sv | 22 ++
 rtl/fetch_dispatch_fsm.sv | 125 ++++++++++++
 tb/tb_fetch_dispatch_fsm.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fetch_dispatch_if.sv
// fetch_dispatch_if: memory fetch handshake plus dispatch bus between the fetch/dispatch FSM and its neighbours.
interface fetch_dispatch_if #(parameter int PC_W = 8);
    logic            mfc;
    logic [15:0]     instr;
    logic [6:0]      done_vec;
    logic [PC_W-1:0] mem_addr;
    logic            mem_read;
    logic [6:0]      next_fsm;
    logic [5:0]      para1;
    logic [5:0]      para2;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic [1:0]      err_code;
    modport master (
        input  mfc, instr, done_vec,
        output mem_addr, mem_read, next_fsm, para1, para2, pc, halted, err_code
    );
    modport slave (
        output mfc, instr, done_vec,
        input  mem_addr, mem_read, next_fsm, para1, para2, pc, halted, err_code
    );
endinterface

// File: rtl/fetch_dispatch_fsm.sv
// fetch_dispatch_fsm: fetches an instruction, decodes its opcode into a one-hot start pulse
// for the execution FSMs, then waits for the matching completion (or times out into HALT).
module fetch_dispatch_fsm #(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_dispatch_if.master   bus_if
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, WAIT, HALT} state_t;
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d;
    logic            mem_read_q, mem_read_d, halted_q, halted_d;
    logic [15:0]     ir_q, ir_d;
    logic [5:0]      para1_q, para1_d, para2_q, para2_d;
    logic [6:0]      next_fsm_q, next_fsm_d, code_q, code_d, dec;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      err_q, err_d;
    logic [3:0]      op;
    assign op  = ir_q[15:12];
    // A zero code marks the halting opcodes 0000, 1110 and 1111.
    assign dec = (op >= 4'd1 && op <= 4'd6) ? 7'b0000001 :
                 (op == 4'd8 || op == 4'd9) ? 7'b0000010 :
                 (op == 4'd7)               ? 7'b0000100 :
                 (op == 4'd10)              ? 7'b0001000 :
                 (op == 4'd11)              ? 7'b0010000 :
                 (op == 4'd12)              ? 7'b0100000 :
                 (op == 4'd13)              ? 7'b1000000 : 7'b0000000;
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        mem_read_d = mem_read_q;
        halted_d   = halted_q;
        ir_d       = ir_q;
        para1_d    = para1_q;
        para2_d    = para2_q;
        next_fsm_d = next_fsm_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                state_d    = FETCH;
                mem_read_d = 1'b1;
                mem_addr_d = pc_q;
            end
            FETCH: if (bus_if.mfc) begin
                state_d    = DECODE;
                ir_d       = bus_if.instr;
                mem_read_d = 1'b0;
                pc_d       = pc_q + 1'b1;
            end
            DECODE: begin
                para1_d    = ir_q[11:6];
                para2_d    = ir_q[5:0];
                state_d    = (dec != 7'b0) ? WAIT : HALT;
                next_fsm_d = (dec != 7'b0) ? dec : 7'b1111111;
                err_d      = (dec != 7'b0) ? 2'b00 : 2'b01;
                halted_d   = (dec == 7'b0);
                code_d     = dec;
                cnt_d      = '0;
            end
            WAIT: begin
                next_fsm_d = 7'b0000000;
                cnt_d      = cnt_q + 1'b1;
                // Completion is tested first so it beats a coincident timeout.
                if ((bus_if.done_vec & code_q) != 7'b0) begin
                    state_d    = FETCH;
                    mem_read_d = 1'b1;
                    mem_addr_d = pc_q;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d    = HALT;
                    next_fsm_d = 7'b1111111;
                    err_d      = 2'b10;
                    halted_d   = 1'b1;
                end
            end
            default: begin
                mem_read_d = 1'b0;
                halted_d   = 1'b1;
                next_fsm_d = 7'b1111111;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            mem_addr_q <= '0;
            mem_read_q <= 1'b0;
            halted_q   <= 1'b0;
            ir_q       <= '0;
            para1_q    <= '0;
            para2_q    <= '0;
            next_fsm_q <= '0;
            code_q     <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            mem_read_q <= mem_read_d;
            halted_q   <= halted_d;
            ir_q       <= ir_d;
            para1_q    <= para1_d;
            para2_q    <= para2_d;
            next_fsm_q <= next_fsm_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end
    assign bus_if.mem_addr = mem_addr_q;
    assign bus_if.mem_read = mem_read_q;
    assign bus_if.next_fsm = next_fsm_q;
    assign bus_if.para1    = para1_q;
    assign bus_if.para2    = para2_q;
    assign bus_if.pc       = pc_q;
    assign bus_if.halted   = halted_q;
    assign bus_if.err_code = err_q;
endmodule

// File: tb/tb_fetch_dispatch_fsm.sv
// tb_fetch_dispatch_fsm: directed vector table plus hand-written corner sequences for fetch_dispatch_fsm.
module tb_fetch_dispatch_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [7:0] exp_pc = 8'd0;
    fetch_dispatch_if #(.PC_W(8)) bus ();
    fetch_dispatch_fsm #(.PC_W(8), .TIMEOUT(64)) dut (.clk(clk), .rst_n(rst_n), .bus_if(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [15:0] instr;
        logic [6:0]  code;
        logic [5:0]  p1;
        logic [5:0]  p2;
    } vec_t;
    vec_t vecs[11];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(negedge clk);
    endtask
    task automatic do_reset();
        bus.mfc = 1'b0;
        bus.instr = 16'h0;
        bus.done_vec = 7'h0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        exp_pc = 8'd0;
    endtask
    // Fetch with immediate mfc, then check the decode results; returns with the DUT in its first WAIT cycle (or HALT).
    task automatic dispatch(input logic [15:0] instr, input logic [6:0] code, input logic [5:0] p1, input logic [5:0] p2);
        int n = 0;
        while (!bus.mem_read && n < 16) begin
            step();
            n++;
        end
        chk("fetch_req", {31'd0, bus.mem_read}, 32'd1);
        chk("fetch_addr", {24'd0, bus.mem_addr}, {24'd0, exp_pc});
        bus.mfc = 1'b1;
        bus.instr = instr;
        step();
        bus.mfc = 1'b0;
        exp_pc = exp_pc + 8'd1;
        chk("pc_inc", {24'd0, bus.pc}, {24'd0, exp_pc});
        chk("read_drop", {31'd0, bus.mem_read}, 32'd0);
        step();
        chk("next_fsm", {25'd0, bus.next_fsm}, {25'd0, code});
        chk("para1", {26'd0, bus.para1}, {26'd0, p1});
        chk("para2", {26'd0, bus.para2}, {26'd0, p2});
        chk("halted", {31'd0, bus.halted}, {31'd0, code == 7'h7f});
        chk("err", {30'd0, bus.err_code}, code == 7'h7f ? 32'd1 : 32'd0);
    endtask
    task automatic complete(input logic [6:0] code);
        bus.done_vec = code;
        step();
        bus.done_vec = 7'h0;
        chk("refetch_req", {31'd0, bus.mem_read}, 32'd1);
        chk("refetch_addr", {24'd0, bus.mem_addr}, {24'd0, exp_pc});
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
    initial begin
        vecs[0]  = '{16'h1083, 7'b0000001, 6'd2,  6'd3};
        vecs[1]  = '{16'h6fff, 7'b0000001, 6'd63, 6'd63};
        vecs[2]  = '{16'h7040, 7'b0000100, 6'd1,  6'd0};
        vecs[3]  = '{16'h8041, 7'b0000010, 6'd1,  6'd1};
        vecs[4]  = '{16'h9abc, 7'b0000010, 6'd42, 6'd60};
        vecs[5]  = '{16'ha123, 7'b0001000, 6'd4,  6'd35};
        vecs[6]  = '{16'hb7c5, 7'b0010000, 6'd31, 6'd5};
        vecs[7]  = '{16'hc000, 7'b0100000, 6'd0,  6'd0};
        vecs[8]  = '{16'hd03f, 7'b1000000, 6'd0,  6'd63};
        vecs[9]  = '{16'he555, 7'b1111111, 6'd21, 6'd21};
        vecs[10] = '{16'hf000, 7'b1111111, 6'd0,  6'd0};
        bus.mfc = 1'b0;
        bus.instr = 16'h0;
        bus.done_vec = 7'h0;
        #1;
        chk("rst_read", {31'd0, bus.mem_read}, 32'd0);
        chk("rst_fsm", {25'd0, bus.next_fsm}, 32'd0);
        // Reset release: fetch request within two edges, address 0.
        do_reset();
        chk("idle_read", {31'd0, bus.mem_read}, 32'd0);
        step();
        step();
        chk("boot_read", {31'd0, bus.mem_read}, 32'd1);
        chk("boot_addr", {24'd0, bus.mem_addr}, 32'd0);
        // NOT with mfc delayed three cycles.
        repeat (3) step();
        chk("fetch_hold", {31'd0, bus.mem_read}, 32'd1);
        dispatch(16'h7040, 7'b0000100, 6'd1, 6'd0);
        chk("not_pc", {24'd0, bus.pc}, 32'd1);
        step();
        chk("not_one_cycle", {25'd0, bus.next_fsm}, 32'd0);
        complete(7'b0000100);
        chk("not_next_addr", {24'd0, bus.mem_addr}, 32'd1);
        // Asynchronous reset mid-FETCH with the request high.
        #2 rst_n = 1'b0;
        #1;
        chk("async_read", {31'd0, bus.mem_read}, 32'd0);
        chk("async_pc", {24'd0, bus.pc}, 32'd0);
        chk("async_addr", {24'd0, bus.mem_addr}, 32'd0);
        chk("async_p1", {26'd0, bus.para1}, 32'd0);
        chk("async_halt", {31'd0, bus.halted}, 32'd0);
        do_reset();
        // Wrong done ignored while waiting on ADD.
        dispatch(16'h1083, 7'b0000001, 6'd2, 6'd3);
        step();
        bus.done_vec = 7'b0000100;
        step();
        bus.done_vec = 7'h0;
        step();
        chk("wrong_done_read", {31'd0, bus.mem_read}, 32'd0);
        chk("wrong_done_p1", {26'd0, bus.para1}, 32'd2);
        complete(7'b0000001);
        // Table: every opcode class, reset after a halting one.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            dispatch(vecs[i].instr, vecs[i].code, vecs[i].p1, vecs[i].p2);
            if (vecs[i].code == 7'h7f) begin
                do_reset();
            end else begin
                step();
                chk("tbl_one_cycle", {25'd0, bus.next_fsm}, 32'd0);
                complete(vecs[i].code);
            end
        end
        // Illegal opcode 0000 halts and ignores further mfc/done.
        do_reset();
        dispatch(16'h0000, 7'b1111111, 6'd0, 6'd0);
        bus.mfc = 1'b1;
        bus.done_vec = 7'h7f;
        repeat (4) step();
        bus.mfc = 1'b0;
        bus.done_vec = 7'h0;
        chk("halt_read", {31'd0, bus.mem_read}, 32'd0);
        chk("halt_fsm", {25'd0, bus.next_fsm}, 32'h7f);
        chk("halt_flag", {31'd0, bus.halted}, 32'd1);
        chk("halt_err", {30'd0, bus.err_code}, 32'd1);
        // Timeout: 64 WAIT cycles without done.
        do_reset();
        dispatch(16'hc000, 7'b0100000, 6'd0, 6'd0);
        repeat (63) step();
        chk("to_not_yet", {31'd0, bus.halted}, 32'd0);
        step();
        chk("to_halt", {31'd0, bus.halted}, 32'd1);
        chk("to_err", {30'd0, bus.err_code}, 32'd2);
        chk("to_fsm", {25'd0, bus.next_fsm}, 32'h7f);
        chk("to_read", {31'd0, bus.mem_read}, 32'd0);
        // Done on the final WAIT cycle beats the timeout.
        do_reset();
        dispatch(16'hc000, 7'b0100000, 6'd0, 6'd0);
        repeat (63) step();
        complete(7'b0100000);
        chk("late_done_halt", {31'd0, bus.halted}, 32'd0);
        chk("late_done_err", {30'd0, bus.err_code}, 32'd0);
        // PC wrap over 256 back-to-back MOVs.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            dispatch(16'ha000, 7'b0001000, 6'd0, 6'd0);
            complete(7'b0001000);
        end
        chk("wrap_addr", {24'd0, bus.mem_addr}, 32'd0);
        chk("wrap_pc", {24'd0, bus.pc}, 32'd0);
        chk("wrap_halt", {31'd0, bus.halted}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
